fft512_frame_feeder: RTL and testbench

Frame buffer and Avalon-ST transmitter feeding the 512-point FFT core's sink port. It accepts a free-running complex sample stream from the front end (one sample per `in_valid` pulse), packs it into 512-sample frames in a two-bank ping-pong RAM, and streams each complete frame into the FFT with `sop`/`eop` framing under `valid`/`ready` flow control. When both banks are occupied, it drops whole frames so that every packet is exactly 512 contiguous samples.

---
 rtl/fft512_frame_feeder.sv | 196 +++++++++++++++++++
 tb/tb_fft512_frame_feeder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft512_frame_feeder.sv
// Ping-pong frame buffer that packs a free-running complex sample stream into
// N-sample frames and streams each complete frame to the FFT sink over Avalon-ST.
module fft512_frame_feeder #(
  parameter int DW    = 12,
  parameter int N     = 512,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_real,
  input  logic signed [DW-1:0] in_imag,
  input  logic                 inverse_req,
  input  logic                 overflow_clr,
  output logic                 fft_sink_valid,
  input  logic                 fft_sink_ready,
  output logic                 fft_sink_sop,
  output logic                 fft_sink_eop,
  output logic [1:0]           fft_sink_error,
  output logic signed [DW-1:0] fft_sink_real,
  output logic signed [DW-1:0] fft_sink_imag,
  output logic                 fft_inverse,
  output logic                 overflow,
  output logic [CNT_W-1:0]     frames_dropped,
  output logic                 busy
);
  localparam int AW = $clog2(N);

  typedef enum logic {W_FILL, W_DROP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} rstate_t;

  wstate_t         wstate;
  rstate_t         rstate;
  logic [AW-1:0]   wr_idx;
  logic            wr_bank;
  logic [1:0]      full;
  logic [1:0]      set_full;
  logic [1:0]      clr_full;
  logic            wr_en;
  logic            frame_done;
  logic            drop_done;

  logic [2*DW-1:0] mem0 [N];
  logic [2*DW-1:0] mem1 [N];

  logic [AW-1:0]   iss_addr;
  logic            iss_bank;
  logic            rd_bank;

  logic [2*DW-1:0] data_p1, data_p2;
  logic            sop_p1, eop_p1, vld_p1;
  logic            sop_p2, eop_p2, vld_p2;

  logic            out_valid, pop, issue, keep_p2, move, eop_xfer;
  logic [1:0]      occ;
  logic            n_vld_p1, n_vld_p2, n_sop_p1, n_sop_p2, n_head_sop, latch_inv;
  logic [2*DW-1:0] head_data;
  logic            head_sop, head_eop;

  assign wr_en      = (wstate == W_FILL) && in_valid && !(wr_idx == '0 && full[wr_bank]);
  assign frame_done = wr_en && (wr_idx == AW'(N-1));
  assign drop_done  = (wstate == W_DROP) && in_valid && (wr_idx == AW'(N-1));
  assign set_full   = {frame_done & wr_bank, frame_done & ~wr_bank};
  assign clr_full   = {eop_xfer & rd_bank, eop_xfer & ~rd_bank};

  // Writer: fills the current bank or discards a whole frame when it is still occupied
  always_ff @(posedge clk) begin
    if (reset) begin
      wstate         <= W_FILL;
      wr_idx         <= '0;
      wr_bank        <= 1'b0;
      overflow       <= 1'b0;
      frames_dropped <= '0;
    end else begin
      case (wstate)
        W_FILL: begin
          if (in_valid) begin
            if (wr_idx == '0 && full[wr_bank]) begin
              wstate <= W_DROP;
              wr_idx <= AW'(1);
            end else begin
              wr_idx <= wr_idx + AW'(1);
              if (wr_idx == AW'(N-1)) wr_bank <= ~wr_bank;
            end
          end
        end
        W_DROP: begin
          if (in_valid) begin
            wr_idx <= wr_idx + AW'(1);
            if (wr_idx == AW'(N-1)) wstate <= W_FILL;
          end
        end
        default: wstate <= W_FILL;
      endcase
      if (drop_done) begin
        overflow <= 1'b1;
        if (frames_dropped != '1) frames_dropped <= frames_dropped + CNT_W'(1);
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) full <= 2'b00;
    else       full <= (full | set_full) & ~clr_full;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_bank) mem1[wr_idx] <= {in_real, in_imag};
      else         mem0[wr_idx] <= {in_real, in_imag};
    end
  end

  // Output stage: p1 is the RAM read register, p2 the skid slot holding the older beat
  assign out_valid = vld_p1 | vld_p2;
  assign head_data = vld_p2 ? data_p2 : data_p1;
  assign head_sop  = vld_p2 ? sop_p2 : sop_p1;
  assign head_eop  = vld_p2 ? eop_p2 : eop_p1;

  always_comb begin
    pop        = out_valid && fft_sink_ready;
    occ        = {1'b0, vld_p1} + {1'b0, vld_p2} - {1'b0, pop};
    issue      = (rstate != R_IDLE) && (occ != 2'd2);
    keep_p2    = vld_p2 && !pop;
    move       = issue && (occ == 2'd1) && !keep_p2;
    n_vld_p1   = issue ? 1'b1 : (vld_p1 && !(pop && !vld_p2));
    n_vld_p2   = issue ? (occ == 2'd1) : keep_p2;
    n_sop_p1   = issue ? (iss_addr == '0) : sop_p1;
    n_sop_p2   = move ? sop_p1 : sop_p2;
    n_head_sop = n_vld_p2 ? n_sop_p2 : (n_vld_p1 && n_sop_p1);
    latch_inv  = n_head_sop && !(out_valid && !pop);
    eop_xfer   = pop && head_eop;
  end

  // Stage p1/p2 data: registered RAM read and skid capture
  always_ff @(posedge clk) begin
    if (move) begin
      data_p2 <= data_p1;
      sop_p2  <= sop_p1;
      eop_p2  <= eop_p1;
    end
    if (issue) begin
      data_p1 <= iss_bank ? mem1[iss_addr] : mem0[iss_addr];
      sop_p1  <= (iss_addr == '0);
      eop_p1  <= (iss_addr == AW'(N-1));
    end
  end

  // Reader: address issue runs ahead of the beat transfers by at most two entries
  always_ff @(posedge clk) begin
    if (reset) begin
      rstate      <= R_IDLE;
      iss_addr    <= '0;
      iss_bank    <= 1'b0;
      rd_bank     <= 1'b0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      fft_inverse <= 1'b0;
    end else begin
      vld_p1 <= n_vld_p1;
      vld_p2 <= n_vld_p2;
      if (latch_inv) fft_inverse <= inverse_req;
      if (eop_xfer)  rd_bank <= ~rd_bank;
      case (rstate)
        R_IDLE:  if (full[iss_bank]) rstate <= R_FETCH;
        R_FETCH: begin
          if (issue) begin
            iss_addr <= iss_addr + AW'(1);
            rstate   <= R_STREAM;
          end
        end
        R_STREAM: begin
          if (issue) begin
            iss_addr <= iss_addr + AW'(1);
            if (iss_addr == AW'(N-1)) begin
              iss_bank <= ~iss_bank;
              if (!full[~iss_bank]) rstate <= R_IDLE;
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  assign fft_sink_valid = out_valid;
  assign fft_sink_sop   = out_valid && head_sop;
  assign fft_sink_eop   = out_valid && head_eop;
  assign fft_sink_error = 2'b00;
  assign fft_sink_real  = out_valid ? $signed(head_data[2*DW-1:DW]) : '0;
  assign fft_sink_imag  = out_valid ? $signed(head_data[DW-1:0]) : '0;
  assign busy           = (|full) || (rstate != R_IDLE) || out_valid;

endmodule

// File: tb/tb_fft512_frame_feeder.sv
// Scoreboard bench for fft512_frame_feeder: stimulus queues expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_fft512_frame_feeder;
  localparam int DW = 12;
  localparam int N = 512;
  localparam int CNT_W = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic signed [DW-1:0] in_real, in_imag;
  logic                 inverse_req, overflow_clr;
  logic                 fft_sink_valid, fft_sink_ready, fft_sink_sop, fft_sink_eop;
  logic [1:0]           fft_sink_error;
  logic signed [DW-1:0] fft_sink_real, fft_sink_imag;
  logic                 fft_inverse, overflow, busy;
  logic [CNT_W-1:0]     frames_dropped;

  always #5 clk = ~clk;

  fft512_frame_feeder #(.DW(DW), .N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_real(in_real), .in_imag(in_imag),
    .inverse_req(inverse_req), .overflow_clr(overflow_clr),
    .fft_sink_valid(fft_sink_valid), .fft_sink_ready(fft_sink_ready),
    .fft_sink_sop(fft_sink_sop), .fft_sink_eop(fft_sink_eop),
    .fft_sink_error(fft_sink_error), .fft_sink_real(fft_sink_real),
    .fft_sink_imag(fft_sink_imag), .fft_inverse(fft_inverse), .overflow(overflow),
    .frames_dropped(frames_dropped), .busy(busy)
  );

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [1:0]  err;
    logic [11:0] re;
    logic [11:0] im;
    logic        inv;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    acc_cnt = 0;
  int    b2b = 0;
  int    ready_mode = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ready driver
  initial begin
    fft_sink_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       fft_sink_ready = 1'b0;
        1:       fft_sink_ready = 1'b1;
        default: fft_sink_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor
  initial begin
    beat_t cur, prev_out, e;
    logic  prev_stall, prev_eop_acc;
    prev_stall = 1'b0;
    prev_eop_acc = 1'b0;
    prev_out = '0;
    forever begin
      @(negedge clk);
      cur.sop = fft_sink_sop;
      cur.eop = fft_sink_eop;
      cur.err = fft_sink_error;
      cur.re  = fft_sink_real;
      cur.im  = fft_sink_imag;
      cur.inv = fft_inverse;
      if (reset) begin
        prev_stall = 1'b0;
        prev_eop_acc = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", fft_sink_valid, 1);
          chk("hold_beat", cur, prev_out);
        end
        if (fft_sink_valid && fft_sink_ready) begin
          acc_cnt++;
          if (exp_q.size() == 0) begin
            chk("beat_expected", exp_q.size() > 0, 1);
          end else begin
            e = exp_q.pop_front();
            chk("beat", cur, e);
          end
          if (cur.sop && prev_eop_acc) b2b++;
          prev_eop_acc = cur.eop;
        end else begin
          prev_eop_acc = 1'b0;
        end
        prev_stall = fft_sink_valid && !fft_sink_ready;
        prev_out = cur;
      end
    end
  end

  task automatic do_reset(input string tag);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk({tag, "_valid"}, fft_sink_valid, 0);
    chk({tag, "_sop"}, fft_sink_sop, 0);
    chk({tag, "_eop"}, fft_sink_eop, 0);
    chk({tag, "_error"}, fft_sink_error, 0);
    chk({tag, "_real"}, fft_sink_real, 0);
    chk({tag, "_imag"}, fft_sink_imag, 0);
    chk({tag, "_inverse"}, fft_inverse, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_dropped"}, frames_dropped, 0);
    chk({tag, "_busy"}, busy, 0);
    @(posedge clk);
    #1;
  endtask

  // mode 0: real=k imag=-k; mode 1: real=511-k imag=k
  task automatic send(input int start, input int count, input int mode,
                      input logic [1:0] inv_exp, input int push_n, input bit inv_toggle);
    beat_t b;
    for (int k = start; k < start + count; k++) begin
      in_valid = 1'b1;
      in_real  = (mode != 0) ? 12'(511 - k) : 12'(k);
      in_imag  = (mode != 0) ? 12'(k) : 12'(-k);
      if (inv_toggle) inverse_req = ((k / 100) % 2) == 1;
      if (k < push_n) begin
        b.sop = (k % 512) == 0;
        b.eop = (k % 512) == 511;
        b.err = 2'b00;
        b.re  = in_real;
        b.im  = in_imag;
        b.inv = inv_exp[k / 512];
        exp_q.push_back(b);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && (exp_q.size() != 0 || fft_sink_valid); i++) @(negedge clk);
    chk({tag, "_drained"}, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    reset = 1'b1;
    in_valid = 1'b0;
    in_real = '0;
    in_imag = '0;
    inverse_req = 1'b0;
    overflow_clr = 1'b0;
    @(posedge clk);
    #1;
    do_reset("por");

    // basic frame with latency checks
    ready_mode = 1;
    send(0, 512, 0, 2'b00, 512, 0);
    @(negedge clk);
    chk("lat_e0_valid", fft_sink_valid, 0);
    chk("lat_e0_busy", busy, 1);
    @(negedge clk);
    chk("lat_e1_valid", fft_sink_valid, 0);
    @(negedge clk);
    chk("lat_e2_valid", fft_sink_valid, 1);
    chk("lat_e2_sop", fft_sink_sop, 1);
    wait_drain("basic", 2000);
    chk("basic_idle_busy", busy, 0);

    // backpressure
    do_reset("rst_bp");
    ready_mode = 2;
    send(0, 512, 0, 2'b00, 512, 0);
    wait_drain("bp", 6000);
    ready_mode = 1;

    // back-to-back frames
    do_reset("rst_b2b");
    b2b = 0;
    send(0, 1024, 0, 2'b00, 1024, 0);
    wait_drain("b2b", 3000);
    chk("b2b_adjacent", b2b, 1);

    // overflow
    do_reset("rst_ovf");
    ready_mode = 0;
    send(0, 1024, 0, 2'b00, 1024, 0);
    @(negedge clk);
    chk("ovf_two_stored_flag", overflow, 0);
    chk("ovf_two_stored_cnt", frames_dropped, 0);
    @(posedge clk);
    #1;
    send(1024, 512, 0, 2'b00, 1024, 0);
    @(negedge clk);
    chk("ovf_drop1_flag", overflow, 1);
    chk("ovf_drop1_cnt", frames_dropped, 1);
    @(posedge clk);
    #1;
    send(1536, 512, 0, 2'b00, 1024, 0);
    @(negedge clk);
    chk("ovf_drop2_cnt", frames_dropped, 2);
    chk("ovf_busy", busy, 1);
    @(posedge clk);
    #1;
    b2b = 0;
    ready_mode = 1;
    wait_drain("ovf", 3000);
    chk("ovf_b2b", b2b, 1);
    overflow_clr = 1'b1;
    @(posedge clk);
    #1;
    overflow_clr = 1'b0;
    @(negedge clk);
    chk("ovf_clr_flag", overflow, 0);
    chk("ovf_clr_cnt", frames_dropped, 2);
    @(posedge clk);
    #1;

    // inverse latch: toggles every 100 samples, frame 0 sop sees 1, frame 1 sop sees 0
    do_reset("rst_inv");
    send(0, 1024, 0, 2'b01, 1024, 1);
    wait_drain("inv", 3000);
    inverse_req = 1'b0;

    // mid-packet reset
    do_reset("rst_mid_pre");
    base = acc_cnt;
    send(0, 512, 0, 2'b00, 512, 0);
    for (int i = 0; i < 2000 && (acc_cnt - base) < 200; i++) @(negedge clk);
    chk("mid_reached_200", (acc_cnt - base) >= 200, 1);
    do_reset("rst_mid");
    send(0, 512, 1, 2'b00, 512, 0);
    wait_drain("mid_after", 2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
